fifo_param: RTL and testbench
=============================

// Module: fifo_param
// PURPOSE
// - Parametrised synchronous FIFO; next generation of the team's 8x32 FIFO.
// - Single clock; configurable width/depth; all DEPTH entries usable.
// - Adds occupancy count, almost-full/almost-empty flags, overflow/underflow pulses
//   and an optional first-word-fall-through (FWFT) read mode.
// - Buffers byte/word streams between producer and consumer logic in the same clock domain.
// PARAMETERS
// - DATA_W     8   data word width in bits (>=1)
// - DEPTH      32  storage entries; power of 2, >=4
// - AF_THRESH  28  almost_full asserts when count >= AF_THRESH (1..DEPTH)
// - AE_THRESH  4   almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
// - FWFT       0   0 = standard read (data after rd); 1 = head word presented before rd
// PORTS
// - clk           in   1                rising-edge clock
// - rst_n         in   1                asynchronous active-low reset
// - wr            in   1                write request
// - data_in       in   DATA_W           write data
// - rd            in   1                read request / pop
// - data_out      out  DATA_W           read data (registered)
// - full          out  1                count == DEPTH
// - empty         out  1                no word readable
// - almost_full   out  1                count >= AF_THRESH
// - almost_empty  out  1                count <= AE_THRESH
// - count         out  $clog2(DEPTH)+1  words held (includes FWFT output register)
// - overflow      out  1                1-cycle pulse: wr while full (write dropped)
// - underflow     out  1                1-cycle pulse: rd while empty (read ignored)
// BEHAVIOUR
// - Reset (async assert, sync release): pointers=0, count=0, data_out=0, empty=1,
//   almost_empty=1, full=0, almost_full=0 (AF_THRESH>0), overflow=underflow=0.
//   Memory contents not reset. Reset mid-operation discards all contents immediately.
// - Pointers are $clog2(DEPTH)+1 bits; MSB is the wrap bit; address = low bits.
//   full when addresses equal and wrap bits differ; wraps modulo 2*DEPTH naturally.
// - Write accepted iff wr && !full: mem[wr_addr] <= data_in, wr_ptr++.
// - Read accepted iff rd && !empty. A write when full is dropped even if rd is
//   accepted in the same cycle. A read when empty is ignored even if wr is accepted in the same cycle.
// - Simultaneous accepted wr+rd: count unchanged; both pointers advance.
// - All flags and count are registered: they reflect the state after each clock edge, with no combinational path from wr/rd.
// - FWFT=0: accepted rd at edge N -> data_out = head word after edge N; data_out
//   holds its last value otherwise. Write at edge N makes empty=0 after edge N.
// - FWFT=1: output register + valid bit (states OUT_EMPTY/OUT_VALID). When the
//   output register is empty and RAM is non-empty, the head word is prefetched
//   on the next edge. Write at edge N into an empty FIFO -> data_out valid, empty=0 after edge N+1.
//   Accepted rd with RAM non-empty refills the register on the same edge (back-to-back pops at
//   full rate); with RAM empty -> OUT_EMPTY, empty=1. data_out holds its
//   last value while empty. full/count include the output register (capacity DEPTH).
// - overflow/underflow are single-cycle pulses in the cycle after the offending request; they are not sticky.
// STRUCTURE
// - Package fifo_pkg: ptr_w(depth) function, out_state_e enum {OUT_EMPTY, OUT_VALID}.
// - Sub-module fifo_param_ram: simple dual-port RAM, 1 write port, 1 sync read port,
//   DATA_W x DEPTH, no reset. fifo_param holds pointers, flags, count and the FWFT stage.
// TESTING (DATA_W=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1; both FWFT values)
// - Reset: drop rst_n mid-burst, asynchronously -> empty=1, count=0, data_out=0 before the next clk edge.
// - Fill: write 0x01..0x08 -> almost_full after the 6th write, full=1 and count=8 after the 8th write;
//   a 9th write (0xFF) -> overflow pulse, contents unchanged.
// - Drain: read 8 -> data 0x01..0x08 in order, almost_empty once count<=1, empty after the
//   last read; an extra rd -> underflow pulse, data_out holds 0x08.
// - Wrap: 20 rounds of write 5 / read 5 with incrementing data -> ordering intact across
//   pointer wrap; count returns to 0 after each round.
// - Simultaneous: with count=4, assert wr+rd for 10 cycles -> count stays 4 and output data in order;
//   when full, wr+rd -> read accepted, write dropped, overflow=1, count=7.
// - FWFT=1: a single write of 0xA5 into the empty FIFO -> data_out=0xA5, empty=0 exactly 2 edges later,
//   with no rd asserted.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO.
package fifo_pkg;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_VALID = 1'b1
   } out_state_e;

   // Pointer width: address bits plus one wrap bit.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_param_ram.sv
// Simple dual-port storage for fifo_param: one write port, one registered read port.
module fifo_param_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32,
   parameter int AW     = 5
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and optional first-word-fall-through output.
//
// state     | meaning (FWFT=1 output stage)
// OUT_EMPTY | output register holds no readable word, empty=1
// OUT_VALID | output register presents the head word, empty=0
module fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 32,
   parameter int AF_THRESH = 28,
   parameter int AE_THRESH = 4,
   parameter int FWFT      = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     rd,
   output logic [DATA_W-1:0]        data_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     count_q, count_d;
   logic [PW-1:0]     ram_cnt;
   out_state_e        out_state_q, out_state_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              af_q, af_d;
   logic              ae_q, ae_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              dout_live_q, dout_live_d;
   logic              wr_acc, rd_acc, ram_rd_en, valid_d;
   logic [DATA_W-1:0] ram_rd_data;

   fifo_param_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_data (data_in),
      .rd_en   (ram_rd_en),
      .rd_addr (rd_ptr_q[AW-1:0]),
      .rd_data (ram_rd_data)
   );

   always_comb begin
      ram_cnt     = wr_ptr_q - rd_ptr_q;
      wr_acc      = wr && !full_q;
      rd_acc      = rd && !empty_q;
      ram_rd_en   = 1'b0;
      out_state_d = out_state_q;
      if (FWFT != 0) begin
         // Refill the output register whenever it is free or being popped.
         ram_rd_en = (ram_cnt != '0) && ((out_state_q == OUT_EMPTY) || rd_acc);
         if (ram_rd_en)   out_state_d = OUT_VALID;
         else if (rd_acc) out_state_d = OUT_EMPTY;
      end else begin
         ram_rd_en   = rd_acc;
         out_state_d = OUT_EMPTY;
      end
      valid_d     = (FWFT != 0) && (out_state_d == OUT_VALID);
      wr_ptr_d    = wr_ptr_q + PW'(wr_acc);
      rd_ptr_d    = rd_ptr_q + PW'(ram_rd_en);
      count_d     = (wr_ptr_d - rd_ptr_d) + PW'(valid_d);
      full_d      = (count_d == PW'(DEPTH));
      empty_d     = (FWFT != 0) ? !valid_d : (wr_ptr_d == rd_ptr_d);
      af_d        = int'(count_d) >= AF_THRESH;
      ae_d        = int'(count_d) <= AE_THRESH;
      ovf_d       = wr && full_q;
      unf_d       = rd && empty_q;
      dout_live_d = dout_live_q || ram_rd_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_state_q <= OUT_EMPTY;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         af_q        <= 1'b0;
         ae_q        <= 1'b1;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         dout_live_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_state_q <= out_state_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         af_q        <= af_d;
         ae_q        <= ae_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         dout_live_q <= dout_live_d;
      end
   end

   // The RAM read register has no reset; mask it until it has been loaded once.
   assign data_out     = dout_live_q ? ram_rd_data : '0;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: both FWFT modes driven in parallel
// against queue-based reference models.
module tb_fifo_param;

   localparam int DW  = 8;
   localparam int DP  = 8;
   localparam int AFT = 6;
   localparam int AET = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr = 1'b0;
   logic          rd = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic [DW-1:0] u0_dout, u1_dout;
   logic [3:0]    u0_count, u1_count;
   logic u0_full, u0_empty, u0_af, u0_ae, u0_ovf, u0_unf;
   logic u1_full, u1_empty, u1_af, u1_ae, u1_ovf, u1_unf;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AFT), .AE_THRESH(AET), .FWFT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .rd(rd),
      .data_out(u0_dout), .full(u0_full), .empty(u0_empty),
      .almost_full(u0_af), .almost_empty(u0_ae), .count(u0_count),
      .overflow(u0_ovf), .underflow(u0_unf)
   );

   fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AFT), .AE_THRESH(AET), .FWFT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .rd(rd),
      .data_out(u1_dout), .full(u1_full), .empty(u1_empty),
      .almost_full(u1_af), .almost_empty(u1_ae), .count(u1_count),
      .overflow(u1_ovf), .underflow(u1_unf)
   );

   // Reference models: q0 = standard mode contents, q1 = all words held in FWFT mode.
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic [DW-1:0] dout0, dout1;
   bit vis1, ovf0, unf0, ovf1, unf1;

   typedef struct {
      bit            w;
      bit            r;
      logic [DW-1:0] d;
      logic [DW-1:0] e_dout;
      logic [3:0]    e_cnt;
      bit            e_full, e_empty, e_af, e_ae, e_ovf, e_unf;
   } vec_t;

   vec_t tbl[18];

   function automatic logic [17:0] pack(input logic [7:0] d, input logic [3:0] c,
                                        input logic f, input logic e, input logic af,
                                        input logic ae, input logic o, input logic u);
      return {d, c, f, e, af, ae, o, u};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [17:0] act0();
      return pack(u0_dout, u0_count, u0_full, u0_empty, u0_af, u0_ae, u0_ovf, u0_unf);
   endfunction

   function automatic logic [17:0] act1();
      return pack(u1_dout, u1_count, u1_full, u1_empty, u1_af, u1_ae, u1_ovf, u1_unf);
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      dout0 = '0; dout1 = '0;
      vis1 = 0; ovf0 = 0; unf0 = 0; ovf1 = 0; unf1 = 0;
   endtask

   task automatic model_edge(input bit w, input bit r, input logic [DW-1:0] d);
      bit full0, emp0, full1;
      full0 = (q0.size() == DP);
      emp0  = (q0.size() == 0);
      ovf0  = w && full0;
      unf0  = r && emp0;
      if (r && !emp0) dout0 = q0.pop_front();
      if (w && !full0) q0.push_back(d);
      full1 = (q1.size() == DP);
      ovf1  = w && full1;
      unf1  = r && !vis1;
      if (r && vis1) void'(q1.pop_front());
      // A word becomes visible only if it was already stored before this edge.
      vis1 = (q1.size() > 0);
      if (vis1) dout1 = q1[0];
      if (w && !full1) q1.push_back(d);
   endtask

   task automatic compare_models(input string tag);
      int s0, s1;
      s0 = q0.size();
      s1 = q1.size();
      chk({tag, "_std"}, 32'(act0()),
          32'(pack(dout0, 4'(s0), s0 == DP, s0 == 0, s0 >= AFT, s0 <= AET, ovf0, unf0)));
      chk({tag, "_fwft"}, 32'(act1()),
          32'(pack(dout1, 4'(s1), s1 == DP, !vis1, s1 >= AFT, s1 <= AET, ovf1, unf1)));
   endtask

   task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input string tag);
      wr = w; rd = r; data_in = d;
      @(posedge clk);
      model_edge(w, r, d);
      #1;
      compare_models(tag);
      wr = 1'b0; rd = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wr = 1'b0; rd = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] dv;

      for (int k = 0; k < 9; k++)
         tbl[k] = '{1'b1, 1'b0, (k < 8) ? 8'(k + 1) : 8'hFF, 8'h00, 4'((k < 8) ? k + 1 : 8),
                    k >= 7, 1'b0, k >= 5, k == 0, k == 8, 1'b0};
      for (int j = 0; j < 9; j++)
         tbl[9 + j] = '{1'b0, 1'b1, 8'h00, 8'((j < 8) ? j + 1 : 8), 4'((j < 8) ? 7 - j : 0),
                        1'b0, j >= 7, j <= 1, j >= 6, 1'b0, j == 8};

      // Reset state
      do_reset();
      chk("reset_std", 32'(act0()), 32'(pack(8'h00, 4'd0, 0, 1, 0, 1, 0, 0)));
      chk("reset_fwft", 32'(act1()), 32'(pack(8'h00, 4'd0, 0, 1, 0, 1, 0, 0)));

      // FWFT head word appears two edges after a write into an empty FIFO
      step(1, 0, 8'hA5, "a5_w");
      chk("a5_empty_edge1", 32'(u1_empty), 32'd1);
      chk("a5_count_edge1", 32'(u1_count), 32'd1);
      step(0, 0, 8'h00, "a5_idle");
      chk("a5_dout_edge2", 32'(u1_dout), 32'hA5);
      chk("a5_empty_edge2", 32'(u1_empty), 32'd0);

      // Fill past full, then drain past empty
      do_reset();
      for (int i = 0; i < 18; i++) begin
         step(tbl[i].w, tbl[i].r, tbl[i].d, "tbl_model");
         chk($sformatf("tbl_%0d", i), 32'(act0()),
             32'(pack(tbl[i].e_dout, tbl[i].e_cnt, tbl[i].e_full, tbl[i].e_empty,
                      tbl[i].e_af, tbl[i].e_ae, tbl[i].e_ovf, tbl[i].e_unf)));
      end
      chk("drain_hold_fwft", 32'(u1_dout), 32'h08);

      // Wrap: 20 rounds of write 5 / read 5
      dv = 8'h10;
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 5; i++) begin
            step(1, 0, dv, "wrap_w");
            dv++;
         end
         for (int i = 0; i < 5; i++) step(0, 1, 8'h00, "wrap_r");
         chk("wrap_cnt_std", 32'(u0_count), 32'd0);
      end

      // Simultaneous wr+rd at count=4, then at full
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h40 + i), "sim_fill");
      for (int i = 0; i < 10; i++) step(1, 1, 8'(8'h50 + i), "sim_wr_rd");
      chk("sim_cnt_std", 32'(u0_count), 32'd4);
      chk("sim_cnt_fwft", 32'(u1_count), 32'd4);
      for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h60 + i), "sim_top");
      step(1, 1, 8'hEE, "full_wr_rd");
      chk("full_wr_rd_ovf_std", 32'(u0_ovf), 32'd1);
      chk("full_wr_rd_cnt_std", 32'(u0_count), 32'd7);
      chk("full_wr_rd_ovf_fwft", 32'(u1_ovf), 32'd1);
      chk("full_wr_rd_cnt_fwft", 32'(u1_count), 32'd7);
      step(0, 0, 8'h00, "ovf_clear");
      chk("ovf_pulse_clear", 32'(u0_ovf), 32'd0);

      // Asynchronous reset in the middle of a burst
      for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h70 + i), "burst");
      wr = 1'b1; data_in = 8'h99;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_std", 32'(act0()), 32'(pack(8'h00, 4'd0, 0, 1, 0, 1, 0, 0)));
      chk("async_rst_fwft", 32'(act1()), 32'(pack(8'h00, 4'd0, 0, 1, 0, 1, 0, 0)));
      do_reset();
      compare_models("post_rst");

      // Randomised traffic
      for (int i = 0; i < 2000; i++) begin
         bit w, r;
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 50);
         step(w, r, 8'($urandom), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
